jam_cost_table: RTL and testbench
=================================

JAM_COST_TABLE -- requirements
Module: jam_cost_table

Interface
REQ-001 Parameter: COST_W, default 7, width of one cost entry.
REQ-002 Parameter: N, default 8, workers and jobs per side; the table holds N*N = 64 entries.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; one clock, synchronous, active-high.
REQ-005 in_valid  input  1  load-stream entry valid.
REQ-006 in_data  input  COST_W  load-stream cost value, worker-major order (index = W*8 + J).
REQ-007 in_ready  output  1  table accepts a load entry this cycle.
REQ-008 reload  input  1  single-cycle request to discard the table and re-load it.
REQ-009 W  input  3  worker index from the downstream assignment engine.
REQ-010 J  input  3  job index from the downstream assignment engine.
REQ-011 Cost  output  COST_W  cost of assigning worker W to job J.
REQ-012 table_ready  output  1  table fully loaded; downstream engine may start.

Function
REQ-013 FSM states: IDLE, LOAD, SERVE.
REQ-014 IDLE -> LOAD unconditionally on the first cycle after reset release.
REQ-015 LOAD: in_ready = 1; an entry is accepted only when in_valid & in_ready on the same edge; it is written to entry ld_cnt.
REQ-016 ld_cnt: 6-bit counter, incremented per accepted entry; in_valid low holds both the counter and the table.
REQ-017 LOAD -> SERVE on the edge accepting entry 63; ld_cnt wraps to 0 on that edge.
REQ-018 SERVE: in_ready = 0 and table_ready = 1 from the cycle after entry 63 is accepted.
REQ-019 In SERVE, in_valid is ignored and the table contents do not change.
REQ-020 Cost = table[{W,J}] combinationally (zero-cycle latency) while table_ready = 1; Cost = 0 otherwise.
REQ-021 reload sampled high in SERVE: next state is LOAD, ld_cnt = 0, and table_ready = 0 from the next cycle.
REQ-022 reload in IDLE or LOAD is ignored; a load in progress continues.
REQ-023 No back-pressure gaps are required: 64 back-to-back entries complete the load in exactly 64 accepting cycles.

Reset
REQ-024 RST high: state = IDLE, ld_cnt = 0, in_ready = 0, table_ready = 0, Cost = 0.
REQ-025 Table storage is not cleared by reset; stale contents are unobservable because Cost is gated by table_ready.
REQ-026 RST asserted mid-LOAD aborts the load; the next load restarts at entry 0.

Configuration
REQ-027 Macro COST_CHECKSUM_EN.
REQ-028 When defined: additional outputs checksum[12:0] and checksum_valid.
REQ-029 checksum accumulates in_data per accepted entry; it is cleared by reset and on entry to LOAD.
REQ-030 The checksum cannot overflow: max 64*127 = 8128 fits in 13 bits.
REQ-031 checksum_valid equals table_ready.
REQ-032 When not defined: the checksum ports and logic are absent; all other behaviour is identical.

Verification
REQ-033 Reset, then stream entries of value (index mod 128) with in_valid held high -> table_ready rises exactly 65 cycles after reset release, and in_ready is low afterwards.
REQ-034 Load entry[i] = i; set W=3, J=5 -> Cost = 29; W=7, J=7 -> Cost = 63; Cost = 0 while loading.
REQ-035 in_valid toggled every other cycle during load -> 64 accepts; table contents match the stream exactly; no entry skipped or duplicated.
REQ-036 In SERVE, pulse reload, then load all entries = 100 -> table_ready low for the whole reload; afterwards Cost = 100 for every W,J.
REQ-037 Assert RST after 30 accepted entries, then load 64 fresh entries -> table equals the fresh data; table_ready after the 64th.
REQ-038 With COST_CHECKSUM_EN defined, load all entries = 127 -> checksum = 8128 with checksum_valid = 1; after reload, checksum restarts from 0.

Source files
------------

// File: rtl/jam_cost_table.sv
// Cost table for an N x N assignment engine: loaded once from a valid-qualified stream, then read combinationally by {W,J}.
// Optional build macro COST_CHECKSUM_EN adds a running sum of the loaded entries (checksum / checksum_valid).
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int N      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic [COST_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     reload,
    input  logic [$clog2(N)-1:0]     W,
    input  logic [$clog2(N)-1:0]     J,
    output logic [COST_W-1:0]        Cost,
    output logic                     table_ready
`ifdef COST_CHECKSUM_EN
    ,
    output logic [12:0]              checksum,
    output logic                     checksum_valid
`endif
);

    localparam int ENTRIES = N * N;
    localparam int IDX_W   = 2 * $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    ld_cnt;
    logic                accept;
    logic [COST_W-1:0]   cost_tbl [ENTRIES];

    assign accept = in_valid && in_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        table_ready = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (accept && (ld_cnt == IDX_W'(ENTRIES - 1))) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                table_ready = 1'b1;
                if (reload) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The counter wraps to 0 naturally on the last accepted entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_cnt <= '0;
        end else if ((state == SERVE) && reload) begin
            ld_cnt <= '0;
        end else if (accept) begin
            ld_cnt <= ld_cnt + 1'b1;
        end
    end

    // Storage is never reset; Cost gating hides stale contents.
    always_ff @(posedge CLK) begin
        if (accept) begin
            cost_tbl[ld_cnt] <= in_data;
        end
    end

    assign Cost = table_ready ? cost_tbl[{W, J}] : '0;

`ifdef COST_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            checksum <= '0;
        end else if ((state != LOAD) && (state_nxt == LOAD)) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + 13'(in_data);
        end
    end

    assign checksum_valid = table_ready;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: randomized loads and lookups checked against an array model of the table.
module tb_jam_cost_table;

    localparam int COST_W  = 7;
    localparam int N       = 8;
    localparam int ENTRIES = N * N;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic [COST_W-1:0] in_data = '0;
    logic              in_ready;
    logic              reload = 1'b0;
    logic [2:0]        W = '0;
    logic [2:0]        J = '0;
    logic [COST_W-1:0] Cost;
    logic              table_ready;
`ifdef COST_CHECKSUM_EN
    logic [12:0]       checksum;
    logic              checksum_valid;
`endif

    jam_cost_table #(.COST_W(COST_W), .N(N)) dut (
        .CLK(CLK),
        .RST(RST),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .reload(reload),
        .W(W),
        .J(J),
        .Cost(Cost),
        .table_ready(table_ready)
`ifdef COST_CHECKSUM_EN
        ,
        .checksum(checksum),
        .checksum_valid(checksum_valid)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cost;
        int tr;
        int cks;
    } exp_t;

    exp_t sb[$];
    int   ref_tbl [ENTRIES];
    int   ref_cks = 0;
    bit   q_vld = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: one expected response per presented lookup.
    always @(negedge CLK) begin
        exp_t e;
        if (q_vld) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = sb.pop_front();
                check("cost", 32'(Cost), e.cost);
                check("table_ready", 32'(table_ready), e.tr);
                check("in_ready", 32'(in_ready), (e.tr != 0) ? 0 : 1);
`ifdef COST_CHECKSUM_EN
                check("checksum", 32'(checksum), e.cks);
                check("checksum_valid", 32'(checksum_valid), e.tr);
`endif
            end
        end
    end

    function automatic int gen_val(input int mode, input int k);
        case (mode)
            0:       return k % 128;
            1:       return 100;
            2:       return 127;
            default: return int'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic push_query(input int w, input int j, input int cost, input int tr);
        W = 3'(w);
        J = 3'(j);
        sb.push_back('{cost, tr, ref_cks});
        q_vld = 1'b1;
    endtask

    // The first edge of every load is the transition into loading and accepts nothing.
    task automatic do_load(input int mode, input bit gaps, input bit rnd_reload,
                           input int stop_after, output int cycles);
        int k = 0;
        int cyc = 0;
        bit first = 1'b1;
        ref_cks = 0;
        in_valid = 1'b1;
        in_data = COST_W'(gen_val(mode, 0));
        forever begin
            @(posedge CLK);
            cyc++;
            if (!first && in_valid) begin
                ref_tbl[k] = int'(in_data);
                ref_cks += int'(in_data);
                k++;
            end
            first = 1'b0;
            #1;
            reload = 1'b0;
            if (k == ENTRIES || k == stop_after) break;
            if (cyc > 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL load_timeout: got %0d accepts expected %0d", k, stop_after);
                break;
            end
            push_query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, 0);
            in_valid = gaps ? ~in_valid : 1'b1;
            in_data = in_valid ? COST_W'(gen_val(mode, k)) : COST_W'($urandom_range(0, 127));
            if (rnd_reload) reload = ($urandom_range(0, 7) == 0);
        end
        in_valid = 1'b0;
        q_vld = 1'b0;
        cycles = cyc;
    endtask

    task automatic query(input int w, input int j);
        @(posedge CLK);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        in_data = COST_W'($urandom_range(0, 127));
        push_query(w, j, ref_tbl[w * N + j], 1);
        @(negedge CLK);
        #1;
        q_vld = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic query_all();
        for (int w = 0; w < N; w++)
            for (int j = 0; j < N; j++)
                query(w, j);
    endtask

    task automatic apply_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        W = 3'($urandom_range(0, 7));
        J = 3'($urandom_range(0, 7));
        @(posedge CLK);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_table_ready", 32'(table_ready), 0);
        check("rst_cost", 32'(Cost), 0);
`ifdef COST_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 0);
`endif
        RST = 1'b0;
    endtask

    task automatic start_reload();
        @(posedge CLK);
        #1;
        reload = 1'b1;
    endtask

    initial begin
        int cyc;
        apply_reset();

        // Back-to-back index load straight out of reset.
        do_load(0, 1'b0, 1'b0, ENTRIES, cyc);
        check("ready_latency", 32'(cyc), 65);
        check("table_ready_after_load", 32'(table_ready), 1);
        check("in_ready_after_load", 32'(in_ready), 0);
        query(3, 5);
        query(7, 7);
        repeat (8) query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

        // Gapped random load with stray reload pulses during loading.
        start_reload();
        do_load(3, 1'b1, 1'b1, ENTRIES, cyc);
        check("table_ready_gapped", 32'(table_ready), 1);
        query_all();

        // Constant 100 reload.
        start_reload();
        do_load(1, 1'b0, 1'b0, ENTRIES, cyc);
        check("reload_latency", 32'(cyc), 65);
        query_all();

        // Constant 127: full-scale checksum, then a reload restarts it.
        start_reload();
        do_load(2, 1'b0, 1'b0, ENTRIES, cyc);
`ifdef COST_CHECKSUM_EN
        check("checksum_full", 32'(checksum), 8128);
        check("checksum_valid_full", 32'(checksum_valid), 1);
`endif
        repeat (4) query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        start_reload();
        do_load(0, 1'b0, 1'b0, ENTRIES, cyc);
        repeat (4) query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

        // Reset after 30 accepts, then a fresh full load.
        start_reload();
        do_load(3, 1'b0, 1'b0, 30, cyc);
        apply_reset();
        do_load(3, 1'b0, 1'b0, ENTRIES, cyc);
        check("ready_latency_after_abort", 32'(cyc), 65);
        query_all();

        @(posedge CLK);
        #1;
        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
